// File: rtl/nvme_irq_pkg.sv
// rtl/nvme_irq_pkg.sv - shared types, constants and vector helper for the CQ interrupt arbiter
//
// Purpose : state encodings, MSI vector clamp limit and the MSI vector-mask function.
// Ports   : none (package).

package nvme_irq_pkg;

  // One-hot state encoding of the arbiter FSM.
  typedef enum logic [3:0] {
    S_IDLE    = 4'b0001,
    S_MSI_REQ = 4'b0010,
    S_LEG_REQ = 4'b0100,
    S_GAP     = 4'b1000
  } irq_state_t;

  // Largest multi-message enable honoured; the core allocates at most 32 vectors.
  localparam logic [2:0] LP_IRQ_MAX_MM = 3'd5;

  // Fold a CQ index onto the vectors the host allocated: idx & ((1<<mm)-1),
  // with mm clamped to LP_IRQ_MAX_MM.
  function automatic logic [7:0] f_msi_vector(input logic [7:0] i_idx,
                                              input logic [2:0] i_mm);
    logic [2:0] v_mm;
    logic [7:0] v_mask;
    v_mm   = (i_mm > LP_IRQ_MAX_MM) ? LP_IRQ_MAX_MM : i_mm;
    v_mask = (8'd1 << v_mm) - 8'd1;
    return i_idx & v_mask;
  endfunction

endpackage

// File: rtl/nvme_irq_rr_sel.sv
// rtl/nvme_irq_rr_sel.sv - combinational round-robin finder over the per-CQ MSI requests
//
// Purpose : find the first set request bit searching upward from i_last+1,
//           wrapping from C_NUM_CQ-1 to 0; i_last itself is checked last.
// Ports   : i_req   [C_NUM_CQ]       request vector
//           i_last  [C_CQ_IDX_WIDTH] index granted most recently
//           o_found                  at least one request is set
//           o_idx   [C_CQ_IDX_WIDTH] winning index (0 when o_found=0)

module nvme_irq_rr_sel
  import nvme_irq_pkg::*;
#(
  parameter int C_NUM_CQ       = 8,
  parameter int C_CQ_IDX_WIDTH = 3
) (
  input  logic [C_NUM_CQ-1:0]       i_req,
  input  logic [C_CQ_IDX_WIDTH-1:0] i_last,
  output logic                      o_found,
  output logic [C_CQ_IDX_WIDTH-1:0] o_idx
);

  always_comb begin
    int v_pos;
    v_pos   = 0;
    o_found = 1'b0;
    o_idx   = '0;
    // Offsets 1..C_NUM_CQ visit every CQ once, starting just after i_last.
    for (int i = 1; i <= C_NUM_CQ; i++) begin
      v_pos = (int'(i_last) + i) % C_NUM_CQ;
      if (!o_found && i_req[v_pos[C_CQ_IDX_WIDTH-1:0]]) begin
        o_found = 1'b1;
        o_idx   = v_pos[C_CQ_IDX_WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/nvme_irq_arbiter.sv
// rtl/nvme_irq_arbiter.sv - serialises per-CQ MSI / legacy interrupts onto the PCIe cfg interrupt port
//
// Purpose : round-robin MSI grant with one-cycle ack back to the CQ; optional
//           legacy INTx emulation (assert/deassert messages tracking the OR of
//           all legacy levels), enabled by defining NVME_IRQ_LEGACY_EN.
// Ports   : pcie_user_clk           clock
//           w_cq_rst_n              async active-low reset
//           pcie_msi_en             MSI enabled by host
//           cfg_interrupt_mmenable  log2 of allocated MSI vectors
//           cq_msi_irq_req          per-CQ MSI request level
//           cq_msi_irq_ack          one-hot one-cycle grant acknowledge
//           cq_legacy_irq_req       per-CQ legacy level
//           cfg_interrupt           request to PCIe core
//           cfg_interrupt_rdy       PCIe core accepted request
//           cfg_interrupt_assert    legacy message type (1 assert, 0 deassert)
//           cfg_interrupt_di        MSI vector number (0 for legacy)

module nvme_irq_arbiter
  import nvme_irq_pkg::*;
#(
  parameter int C_NUM_CQ       = 8,
  parameter int C_CQ_IDX_WIDTH = 3
) (
  input  logic                pcie_user_clk,
  input  logic                w_cq_rst_n,
  input  logic                pcie_msi_en,
  input  logic [2:0]          cfg_interrupt_mmenable,
  input  logic [C_NUM_CQ-1:0] cq_msi_irq_req,
  output logic [C_NUM_CQ-1:0] cq_msi_irq_ack,
  input  logic [C_NUM_CQ-1:0] cq_legacy_irq_req,
  output logic                cfg_interrupt,
  input  logic                cfg_interrupt_rdy,
  output logic                cfg_interrupt_assert,
  output logic [7:0]          cfg_interrupt_di
);

  localparam logic [C_CQ_IDX_WIDTH-1:0] LP_RR_INIT = C_CQ_IDX_WIDTH'(C_NUM_CQ - 1);
  localparam logic [C_NUM_CQ-1:0]       LP_ACK_ONE = C_NUM_CQ'(1);

  irq_state_t                r_state;
  logic [C_CQ_IDX_WIDTH-1:0] r_rr_last;
  logic [C_CQ_IDX_WIDTH-1:0] r_grant;
  logic                      r_intx_state;
  logic                      r_irq;
  logic                      r_assert;
  logic [7:0]                r_di;
  logic [C_NUM_CQ-1:0]       r_ack;

  logic                      w_found;
  logic [C_CQ_IDX_WIDTH-1:0] w_g;
  logic                      w_legacy_any;

`ifdef NVME_IRQ_LEGACY_EN
  assign w_legacy_any = |cq_legacy_irq_req;
`else
  // Legacy levels are ignored in this build; the reduction only keeps the port consumed.
  logic w_unused_legacy;
  assign w_unused_legacy = ^cq_legacy_irq_req;
  assign w_legacy_any    = 1'b0;
`endif

  nvme_irq_rr_sel #(
    .C_NUM_CQ       (C_NUM_CQ),
    .C_CQ_IDX_WIDTH (C_CQ_IDX_WIDTH)
  ) u_rr_sel (
    .i_req   (cq_msi_irq_req),
    .i_last  (r_rr_last),
    .o_found (w_found),
    .o_idx   (w_g)
  );

  always_ff @(posedge pcie_user_clk or negedge w_cq_rst_n) begin
    if (!w_cq_rst_n) begin
      r_state      <= S_IDLE;
      r_rr_last    <= LP_RR_INIT;
      r_grant      <= '0;
      r_intx_state <= 1'b0;
      r_irq        <= 1'b0;
      r_assert     <= 1'b0;
      r_di         <= 8'd0;
      r_ack        <= '0;
    end else begin
      r_ack <= '0;
      case (r_state)
        S_IDLE: begin
          if (pcie_msi_en && r_intx_state) begin
            // Host switched to MSI while INTx is asserted: release it first.
            r_irq    <= 1'b1;
            r_assert <= 1'b0;
            r_di     <= 8'd0;
            r_state  <= S_LEG_REQ;
          end else if (pcie_msi_en && w_found) begin
            r_grant  <= w_g;
            r_irq    <= 1'b1;
            r_assert <= 1'b0;
            r_di     <= f_msi_vector(8'(w_g), cfg_interrupt_mmenable);
            r_state  <= S_MSI_REQ;
          end else if (!pcie_msi_en && (w_legacy_any != r_intx_state)) begin
            r_irq    <= 1'b1;
            r_assert <= w_legacy_any;
            r_di     <= 8'd0;
            r_state  <= S_LEG_REQ;
          end
        end
        S_MSI_REQ: begin
          // Message completes regardless of msi_en or the request dropping meanwhile.
          if (cfg_interrupt_rdy) begin
            r_irq     <= 1'b0;
            r_ack     <= LP_ACK_ONE << r_grant;
            r_rr_last <= r_grant;
            r_state   <= S_GAP;
          end
        end
        S_LEG_REQ: begin
          if (cfg_interrupt_rdy) begin
`ifdef NVME_IRQ_LEGACY_EN
            r_intx_state <= r_assert;
`endif
            r_irq   <= 1'b0;
            r_state <= S_GAP;
          end
        end
        S_GAP: begin
          // Gives the acked CQ a cycle to drop its request before re-arbitration.
          r_state <= S_IDLE;
        end
        default: begin
          r_irq   <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign cfg_interrupt        = r_irq;
  assign cfg_interrupt_assert = r_assert;
  assign cfg_interrupt_di     = r_di;
  assign cq_msi_irq_ack       = r_ack;

endmodule

// File: tb/tb_nvme_irq_arbiter.sv
// tb/tb_nvme_irq_arbiter.sv - directed self-checking bench for nvme_irq_arbiter

module tb_nvme_irq_arbiter;

  logic       clk = 1'b0;
  logic       rstn;
  logic       msi_en;
  logic [2:0] mm;
  logic [7:0] req;
  logic [7:0] ack;
  logic [7:0] legacy;
  logic       irq;
  logic       rdy;
  logic       asrt;
  logic [7:0] di;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  nvme_irq_arbiter #(
    .C_NUM_CQ       (8),
    .C_CQ_IDX_WIDTH (3)
  ) dut (
    .pcie_user_clk          (clk),
    .w_cq_rst_n             (rstn),
    .pcie_msi_en            (msi_en),
    .cfg_interrupt_mmenable (mm),
    .cq_msi_irq_req         (req),
    .cq_msi_irq_ack         (ack),
    .cq_legacy_irq_req      (legacy),
    .cfg_interrupt          (irq),
    .cfg_interrupt_rdy      (rdy),
    .cfg_interrupt_assert   (asrt),
    .cfg_interrupt_di       (di)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rstn = 1'b0; msi_en = 1'b0; mm = 3'd3; req = 8'h00; legacy = 8'h00; rdy = 1'b0;
    tick; tick;
    rstn = 1'b1;
  endtask

  // Waits for an ack pulse; returns the acked index and the di seen while irq was high.
  task automatic wait_ack(input int bound, output int g, output logic [7:0] d, output bit ok);
    g = -1; d = 8'hxx; ok = 1'b0;
    for (int k = 0; k < bound; k++) begin
      tick;
      if (irq === 1'b1) d = di;
      if (ack !== 8'h00) begin
        ok = 1'b1;
        for (int b = 0; b < 8; b++) if (ack[b]) begin g = b; break; end
        break;
      end
    end
  endtask

  task automatic test_reset;
    rstn = 1'b0; msi_en = 1'b1; mm = 3'd3; req = 8'hFF; legacy = 8'hFF; rdy = 1'b1;
    tick;
    n_cmp++; if (irq !== 1'b0)   begin n_err++; $display("FAIL reset_irq got %b want 0", irq); end
    n_cmp++; if (asrt !== 1'b0)  begin n_err++; $display("FAIL reset_assert got %b want 0", asrt); end
    n_cmp++; if (di !== 8'h00)   begin n_err++; $display("FAIL reset_di got %h want 00", di); end
    n_cmp++; if (ack !== 8'h00)  begin n_err++; $display("FAIL reset_ack got %h want 00", ack); end
    do_reset;
  endtask

  task automatic test_basic;
    do_reset;
    msi_en = 1'b1; mm = 3'd3; rdy = 1'b1; req = 8'b0000_0100;
    tick;
    n_cmp++; if (irq !== 1'b1)  begin n_err++; $display("FAIL basic_irq_rise got %b want 1", irq); end
    n_cmp++; if (di !== 8'd2)   begin n_err++; $display("FAIL basic_di got %0d want 2", di); end
    n_cmp++; if (ack !== 8'h00) begin n_err++; $display("FAIL basic_ack_early got %h want 00", ack); end
    tick;
    n_cmp++; if (irq !== 1'b0)  begin n_err++; $display("FAIL basic_irq_fall got %b want 0", irq); end
    n_cmp++; if (ack !== 8'h04) begin n_err++; $display("FAIL basic_ack got %h want 04", ack); end
    tick;
    n_cmp++; if (ack !== 8'h00) begin n_err++; $display("FAIL basic_ack_width got %h want 00", ack); end
    n_cmp++; if (irq !== 1'b0)  begin n_err++; $display("FAIL basic_gap_irq got %b want 0", irq); end
    tick;
    n_cmp++; if (irq !== 1'b1)  begin n_err++; $display("FAIL basic_period3 got %b want 1", irq); end
    req = 8'h00;
    tick;
    n_cmp++; if (ack !== 8'h04) begin n_err++; $display("FAIL basic_ack2 got %h want 04", ack); end
    tick; tick;
    n_cmp++; if (irq !== 1'b0)  begin n_err++; $display("FAIL basic_idle got %b want 0", irq); end
  endtask

  task automatic test_round_robin;
    int         g;
    logic [7:0] d;
    bit         ok;
    int         exp_tail[2] = '{0, 7};
    do_reset;
    msi_en = 1'b1; mm = 3'd3; rdy = 1'b1; req = 8'hFF;
    for (int i = 0; i < 10; i++) begin
      if (i == 8) req = 8'h81;
      wait_ack(20, g, d, ok);
      n_cmp++;
      if (!ok) begin
        n_err++; $display("FAIL rr_timeout grant %0d got none want ack", i);
      end else begin
        if (g !== ((i < 8) ? i : exp_tail[i-8])) begin
          n_err++; $display("FAIL rr_order grant %0d got cq%0d want cq%0d", i, g, (i < 8) ? i : exp_tail[i-8]);
        end
        n_cmp++;
        if (d !== 8'(g)) begin n_err++; $display("FAIL rr_di grant %0d got %0d want %0d", i, d, g); end
        n_cmp++;
        if ($countones(ack) != 1) begin n_err++; $display("FAIL rr_onehot got %h want one-hot", ack); end
        req = req & ~ack;
      end
    end
    req = 8'h00;
    tick; tick;
  endtask

  task automatic test_vectors;
    int         cq_tab[4]  = '{5, 5, 5, 7};
    int         mm_tab[4]  = '{1, 0, 7, 2};
    int         exp_tab[4] = '{1, 0, 5, 3};
    int         g;
    logic [7:0] d;
    bit         ok;
    msi_en = 1'b1; rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mm  = 3'(mm_tab[i]);
      req = 8'(1) << cq_tab[i];
      wait_ack(20, g, d, ok);
      n_cmp++;
      if (!ok) begin
        n_err++; $display("FAIL vec_timeout case %0d got none want ack", i);
      end else if (d !== 8'(exp_tab[i])) begin
        n_err++; $display("FAIL vec_di case %0d got %0d want %0d", i, d, exp_tab[i]);
      end
      req = 8'h00;
      tick;
    end
    tick; tick;
  endtask

  task automatic test_stall;
    bit seen;
    msi_en = 1'b1; mm = 3'd3; rdy = 1'b0; req = 8'h02;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick;
      if (irq === 1'b1) begin seen = 1'b1; break; end
    end
    n_cmp++; if (!seen)       begin n_err++; $display("FAIL stall_rise got irq=%b want 1", irq); end
    n_cmp++; if (di !== 8'd1) begin n_err++; $display("FAIL stall_di0 got %0d want 1", di); end
    for (int c = 1; c <= 10; c++) begin
      if (c == 4) msi_en = 1'b0;
      tick;
      n_cmp++; if (irq !== 1'b1 || di !== 8'd1 || ack !== 8'h00) begin
        n_err++; $display("FAIL stall_hold cycle %0d got irq=%b di=%0d ack=%h want irq=1 di=1 ack=00", c, irq, di, ack);
      end
    end
    rdy = 1'b1;
    tick;
    n_cmp++; if (irq !== 1'b0 || ack !== 8'h02) begin
      n_err++; $display("FAIL stall_done got irq=%b ack=%h want irq=0 ack=02", irq, ack);
    end
    req = 8'h00;
    tick;
    n_cmp++; if (ack !== 8'h00) begin n_err++; $display("FAIL stall_single_ack got %h want 00", ack); end
    tick; tick;
    n_cmp++; if (irq !== 1'b0)  begin n_err++; $display("FAIL stall_idle got %b want 0", irq); end
  endtask

`ifdef NVME_IRQ_LEGACY_EN
  task automatic test_legacy;
    do_reset;
    msi_en = 1'b0; rdy = 1'b1; mm = 3'd3; legacy = 8'h08;
    tick;
    n_cmp++; if (irq !== 1'b1 || asrt !== 1'b1 || di !== 8'h00) begin
      n_err++; $display("FAIL leg_assert got irq=%b asrt=%b di=%h want 1 1 00", irq, asrt, di);
    end
    tick;
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL leg_assert_done got %b want 0", irq); end
    tick; tick;
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL leg_steady got %b want 0", irq); end
    legacy = 8'h00;
    tick;
    n_cmp++; if (irq !== 1'b1 || asrt !== 1'b0) begin
      n_err++; $display("FAIL leg_deassert got irq=%b asrt=%b want 1 0", irq, asrt);
    end
    tick;
    legacy = 8'h08;
    tick; tick;
    n_cmp++; if (irq !== 1'b1 || asrt !== 1'b1) begin
      n_err++; $display("FAIL leg_reassert got irq=%b asrt=%b want 1 1", irq, asrt);
    end
    tick;
    msi_en = 1'b1; req = 8'h10;
    tick; tick;
    n_cmp++; if (irq !== 1'b1 || asrt !== 1'b0 || di !== 8'h00) begin
      n_err++; $display("FAIL leg_msi_deassert got irq=%b asrt=%b di=%h want 1 0 00", irq, asrt, di);
    end
    tick; tick; tick;
    n_cmp++; if (irq !== 1'b1 || di !== 8'd4) begin
      n_err++; $display("FAIL leg_then_msi got irq=%b di=%0d want 1 4", irq, di);
    end
    tick;
    n_cmp++; if (ack !== 8'h10) begin n_err++; $display("FAIL leg_msi_ack got %h want 10", ack); end
    req = 8'h00; legacy = 8'h00;
    tick; tick;
  endtask
`else
  task automatic test_legacy;
    do_reset;
    msi_en = 1'b0; rdy = 1'b1; legacy = 8'hFF; req = 8'hFF;
    for (int k = 0; k < 5; k++) begin
      tick;
      n_cmp++; if (irq !== 1'b0 || asrt !== 1'b0) begin
        n_err++; $display("FAIL legacy_off cycle %0d got irq=%b asrt=%b want 0 0", k, irq, asrt);
      end
    end
    legacy = 8'h00; req = 8'h00;
  endtask
`endif

  task automatic test_reset_mid;
    do_reset;
    msi_en = 1'b1; mm = 3'd3; rdy = 1'b1; req = 8'h01;
    tick; tick;
    n_cmp++; if (ack !== 8'h01) begin n_err++; $display("FAIL rmid_first_ack got %h want 01", ack); end
    req = 8'hFF; rdy = 1'b0;
    tick; tick;
    n_cmp++; if (irq !== 1'b1 || di !== 8'd1) begin
      n_err++; $display("FAIL rmid_pre got irq=%b di=%0d want 1 1", irq, di);
    end
    rstn = 1'b0;
    #1;
    n_cmp++; if (irq !== 1'b0 || asrt !== 1'b0 || di !== 8'h00 || ack !== 8'h00) begin
      n_err++; $display("FAIL rmid_async got irq=%b asrt=%b di=%h ack=%h want all 0", irq, asrt, di, ack);
    end
    tick;
    rstn = 1'b1; rdy = 1'b1;
    tick;
    n_cmp++; if (irq !== 1'b1 || di !== 8'd0) begin
      n_err++; $display("FAIL rmid_cq0_first got irq=%b di=%0d want 1 0", irq, di);
    end
    tick;
    n_cmp++; if (ack !== 8'h01) begin n_err++; $display("FAIL rmid_ack got %h want 01", ack); end
    req = 8'h00;
    tick; tick;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_round_robin;
    test_vectors;
    test_stall;
    test_legacy;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
